vga_line_fetch_buffer: RTL and testbench

VGA_LINE_FETCH_BUFFER -- requirements
Module: vga_line_fetch_buffer

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_bank_mem.sv | 23 ++
 rtl/vga_line_fetch_buffer.sv | 220 ++++++++++++++++++++++
 tb/tb_vga_line_fetch_buffer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA line fetch buffer: fetch FSM states, AXI
// encodings and the self-test palette.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_WAIT = 2'd3
  } fetch_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic logic [11:0] palette(input logic [2:0] idx);
    logic [11:0] rgb;
    case (idx)
      3'd0:    rgb = 12'h000;
      3'd1:    rgb = 12'hFFF;
      3'd2:    rgb = 12'hF00;
      3'd3:    rgb = 12'h0F0;
      3'd4:    rgb = 12'h00F;
      3'd5:    rgb = 12'hFF0;
      3'd6:    rgb = 12'h0FF;
      default: rgb = 12'hF0F;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/vga_bank_mem.sv
// Bank ring storage: one synchronous write port, one asynchronous read port.
module vga_bank_mem #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 64,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk_a,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_a) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/vga_line_fetch_buffer.sv
// AXI burst fetcher filling a ring of line banks that are drained one pixel per request.
// Optional self-test palette output is built when VGA_SELF_TEST_EN is defined.
module vga_line_fetch_buffer
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 32,
  parameter int NUM_BANKS  = 2
) (
  input  logic                  clk_a,
  input  logic                  resetn_a,
  input  logic                  enable_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] top_addr_i,
  input  logic                  pix_req_i,
  output logic [11:0]           pix_o,
  output logic                  pix_valid_o,
  output logic                  underflow_o,
  output logic                  rerr_o,
`ifdef VGA_SELF_TEST_EN
  input  logic                  self_test_i,
  input  logic [2:0]            test_pattern_i,
`endif
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic [7:0]            arlen_o,
  output logic [2:0]            arsize_o,
  output logic [1:0]            arburst_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  output fetch_state_e          state_o
);

  localparam int SLOTS = DATA_WIDTH / 16;
  localparam int DEPTH = NUM_BANKS * BURST_LEN;
  localparam int MAW   = $clog2(DEPTH);
  localparam int BW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int SW    = $clog2(SLOTS);
  localparam int PW    = $clog2(NUM_BANKS);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

  fetch_state_e r_state, w_state_next;
  logic                  r_en_q;
  logic [ADDR_WIDTH-1:0] r_base, r_top, r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_inc, w_addr_wrap;
  logic [NUM_BANKS-1:0]  r_full, w_full_next;
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr, w_wr_ptr_next;
  logic [BW-1:0]         r_wr_beat, r_rd_beat;
  logic [SW-1:0]         r_rd_slot;
  logic [11:0]           r_pix;
  logic                  r_pix_valid, r_underflow, r_rerr;
  logic                  w_beat_fire, w_last_beat, w_rd_avail, w_pix_fire, w_last_slot;
  logic                  w_go_idle, w_self_test;
  logic [MAW-1:0]        w_waddr, w_raddr;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [11:0]           w_slot_pix;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_BANKS - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef VGA_SELF_TEST_EN
  assign w_self_test = self_test_i;
`else
  assign w_self_test = 1'b0;
`endif

  assign w_beat_fire = (r_state == ST_DATA) && rvalid_i;
  assign w_last_beat = w_beat_fire && (r_wr_beat == LAST_BEAT);
  assign w_rd_avail  = r_full[r_rd_ptr];
  assign w_pix_fire  = pix_req_i && !w_self_test && w_rd_avail;
  assign w_last_slot = w_pix_fire && (r_rd_beat == LAST_BEAT) && (r_rd_slot == LAST_SLOT);
  assign w_addr_inc  = r_addr + BURST_BYTES;
  assign w_addr_wrap = (w_addr_inc >= r_top) ? r_base : w_addr_inc;
  assign w_waddr     = MAW'(int'(r_wr_ptr) * BURST_LEN + int'(r_wr_beat));
  assign w_raddr     = MAW'(int'(r_rd_ptr) * BURST_LEN + int'(r_rd_beat));
  assign w_slot_pix  = w_rd_word[{r_rd_slot, 4'b0000} +: 12];

  // Fill and drain touch different banks, so both flag updates apply together.
  always_comb begin
    w_full_next   = r_full;
    w_wr_ptr_next = r_wr_ptr;
    if (w_last_beat) begin
      w_full_next[r_wr_ptr] = 1'b1;
      w_wr_ptr_next         = ptr_inc(r_wr_ptr);
    end
    if (w_last_slot) w_full_next[r_rd_ptr] = 1'b0;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (enable_i) w_state_next = ST_ADDR;
      ST_ADDR: begin
        if (arready_i)     w_state_next = ST_DATA;
        else if (!enable_i) w_state_next = ST_IDLE;
      end
      ST_DATA: begin
        if (w_last_beat) begin
          if (!enable_i)                         w_state_next = ST_IDLE;
          else if (!w_full_next[w_wr_ptr_next]) w_state_next = ST_ADDR;
          else                                   w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!enable_i)               w_state_next = ST_IDLE;
        else if (!r_full[r_wr_ptr]) w_state_next = ST_ADDR;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_go_idle = (r_state != ST_IDLE) && (w_state_next == ST_IDLE);

  always_ff @(posedge clk_a or negedge resetn_a) begin
    if (!resetn_a) begin
      r_state     <= ST_IDLE;
      r_en_q      <= 1'b0;
      r_base      <= '0;
      r_top       <= '0;
      r_addr      <= '0;
      r_full      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_wr_beat   <= '0;
      r_rd_beat   <= '0;
      r_rd_slot   <= '0;
      r_pix       <= '0;
      r_pix_valid <= 1'b0;
      r_underflow <= 1'b0;
      r_rerr      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_en_q  <= enable_i;

      if (r_state == ST_IDLE && enable_i) begin
        r_base <= base_addr_i;
        r_top  <= top_addr_i;
        r_addr <= base_addr_i;
      end else if (w_go_idle) begin
        r_addr <= r_base;
      end else if (r_state == ST_ADDR && arready_i) begin
        r_addr <= w_addr_wrap;
      end

      if (w_go_idle) begin
        r_full    <= '0;
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_wr_beat <= '0;
        r_rd_beat <= '0;
        r_rd_slot <= '0;
      end else begin
        r_full   <= w_full_next;
        r_wr_ptr <= w_wr_ptr_next;
        if (w_beat_fire) r_wr_beat <= (r_wr_beat == LAST_BEAT) ? '0 : r_wr_beat + 1'b1;
        if (w_pix_fire) begin
          if (r_rd_slot == LAST_SLOT) begin
            r_rd_slot <= '0;
            r_rd_beat <= (r_rd_beat == LAST_BEAT) ? '0 : r_rd_beat + 1'b1;
          end else begin
            r_rd_slot <= r_rd_slot + 1'b1;
          end
          if (w_last_slot) r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
      end

      r_pix_valid <= 1'b0;
`ifdef VGA_SELF_TEST_EN
      if (w_self_test && pix_req_i) begin
        r_pix       <= palette(test_pattern_i);
        r_pix_valid <= 1'b1;
      end else
`endif
      if (w_pix_fire) begin
        r_pix       <= w_slot_pix;
        r_pix_valid <= 1'b1;
      end

      // Sticky flags: a new enable clears them, an event on the same edge wins.
      if (enable_i && !r_en_q) begin
        r_underflow <= 1'b0;
        r_rerr      <= 1'b0;
      end
      if (pix_req_i && !w_self_test && !w_rd_avail) r_underflow <= 1'b1;
      if (w_beat_fire && rresp_i != AXI_RESP_OKAY)  r_rerr      <= 1'b1;
    end
  end

  vga_bank_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bank_mem (
    .clk_a   (clk_a),
    .i_we    (w_beat_fire),
    .i_waddr (w_waddr),
    .i_wdata (rdata_i),
    .i_raddr (w_raddr),
    .o_rdata (w_rd_word)
  );

  assign pix_o       = r_pix;
  assign pix_valid_o = r_pix_valid;
  assign underflow_o = r_underflow;
  assign rerr_o      = r_rerr;
  assign araddr_o    = r_addr;
  assign arlen_o     = 8'(BURST_LEN - 1);
  assign arsize_o    = 3'($clog2(DATA_WIDTH / 8));
  assign arburst_o   = AXI_BURST_INCR;
  assign arvalid_o   = (r_state == ST_ADDR);
  assign rready_o    = (r_state == ST_DATA);
  assign state_o     = r_state;

endmodule

// File: tb/tb_vga_line_fetch_buffer.sv
// Randomised bench for vga_line_fetch_buffer: the pixel stream is modelled as a
// flat queue of completed bursts, and the AXI slave is driven from the bench.
module tb_vga_line_fetch_buffer;
  import vga_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BL = 32;
  localparam int NB = 3;
  localparam int SLOTS = DW / 16;
  localparam int PIX_PER_BURST = BL * SLOTS;
  localparam logic [AW-1:0] BYTES = AW'(BL * DW / 8);

  // clock / reset
  logic clk_a = 1'b0;
  logic resetn_a = 1'b0;
  always #5 clk_a = ~clk_a;

  logic          enable_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW-1:0] top_addr_i = '0;
  logic          pix_req_i = 1'b0;
  logic          arready_i = 1'b0;
  logic          rvalid_i = 1'b0;
  logic [DW-1:0] rdata_i = '0;
  logic [1:0]    rresp_i = '0;
  logic [11:0]   pix_o;
  logic          pix_valid_o, underflow_o, rerr_o;
  logic [AW-1:0] araddr_o;
  logic [7:0]    arlen_o;
  logic [2:0]    arsize_o;
  logic [1:0]    arburst_o;
  logic          arvalid_o, rready_o;
  fetch_state_e  state_o;

  vga_line_fetch_buffer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .NUM_BANKS  (NB)
  ) dut (
    .clk_a          (clk_a),
    .resetn_a       (resetn_a),
    .enable_i       (enable_i),
    .base_addr_i    (base_addr_i),
    .top_addr_i     (top_addr_i),
    .pix_req_i      (pix_req_i),
    .pix_o          (pix_o),
    .pix_valid_o    (pix_valid_o),
    .underflow_o    (underflow_o),
    .rerr_o         (rerr_o),
`ifdef VGA_SELF_TEST_EN
    .self_test_i    (1'b0),
    .test_pattern_i (3'd0),
`endif
    .araddr_o       (araddr_o),
    .arlen_o        (arlen_o),
    .arsize_o       (arsize_o),
    .arburst_o      (arburst_o),
    .arvalid_o      (arvalid_o),
    .arready_i      (arready_i),
    .rvalid_i       (rvalid_i),
    .rready_o       (rready_o),
    .rdata_i        (rdata_i),
    .rresp_i        (rresp_i),
    .state_o        (state_o)
  );

  // scoreboard state
  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];
  logic [11:0] stage_q[$];
  logic [11:0] pix_seen[$];
  logic [AW-1:0] ar_log[$];
  logic [11:0] exp_pix = '0;
  logic exp_valid = 1'b0, exp_underflow = 1'b0, exp_rerr = 1'b0;
  logic [AW-1:0] m_base = '0, m_top = '0, m_addr = '0;
  int beats_left = 0, beat_total = 0, ar_count = 0;

  // stimulus knobs
  logic en_next = 1'b0;
  int ar_pct = 100, r_pct = 100, req_pct = 0, resp_pct = 0, err_beat = -1;
  logic [DW-1:0] first_beat = 64'h0ABC_0123_0456_0789;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver + model: one clock cycle per call
  task automatic step();
    logic [DW-1:0] d;
    int nbuf;
    @(negedge clk_a);
    chk("pix_valid", pix_valid_o, exp_valid);
    chk("pix_o", pix_o, exp_pix);
    chk("underflow", underflow_o, exp_underflow);
    chk("rerr", rerr_o, exp_rerr);
    if (arvalid_o) chk("araddr", araddr_o, m_addr);
    if (rready_o) chk("rready_in_burst", beats_left > 0, 1);
    if (pix_valid_o) pix_seen.push_back(pix_o);

    if (en_next && !enable_i) begin
      exp_q.delete();
      stage_q.delete();
      exp_underflow = 1'b0;
      exp_rerr = 1'b0;
      m_base = base_addr_i;
      m_top = top_addr_i;
      m_addr = base_addr_i;
    end
    enable_i = en_next;
    arready_i = ($urandom_range(99) < ar_pct);
    rvalid_i = (beats_left > 0) && ($urandom_range(99) < r_pct);
    d = {$urandom, $urandom};
    if (beat_total == 0) d = first_beat;
    rdata_i = d;
    rresp_i = (beat_total == err_beat || $urandom_range(99) < resp_pct) ? 2'($urandom_range(1, 3)) : 2'd0;
    pix_req_i = ($urandom_range(99) < req_pct);

    nbuf = (exp_q.size() + PIX_PER_BURST - 1) / PIX_PER_BURST;
    if (pix_req_i) begin
      if (exp_q.size() > 0) begin
        exp_pix = exp_q.pop_front();
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
        exp_underflow = 1'b1;
      end
    end else begin
      exp_valid = 1'b0;
    end
    if (rvalid_i && rready_o) begin
      for (int s = 0; s < SLOTS; s++) stage_q.push_back(d[16*s +: 12]);
      if (rresp_i != 2'd0) exp_rerr = 1'b1;
      beat_total++;
      beats_left--;
      if (beats_left == 0) begin
        foreach (stage_q[i]) exp_q.push_back(stage_q[i]);
        stage_q.delete();
      end
    end
    if (arvalid_o && arready_i) begin
      chk("arlen", arlen_o, 8'h1F);
      chk("arsize", arsize_o, 3'd3);
      chk("arburst", arburst_o, 2'b01);
      chk("bank_free_at_ar", nbuf < NB, 1);
      chk("no_overlap_burst", beats_left, 0);
      ar_log.push_back(araddr_o);
      ar_count++;
      beats_left = BL;
      m_addr = m_addr + BYTES;
      if (m_addr >= m_top) m_addr = m_base;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk_a);
    chk("rst_arvalid", arvalid_o, 0);
    chk("rst_rready", rready_o, 0);
    chk("rst_araddr", araddr_o, 0);
    chk("rst_pix", pix_o, 0);
    chk("rst_pix_valid", pix_valid_o, 0);
    chk("rst_underflow", underflow_o, 0);
    chk("rst_rerr", rerr_o, 0);
    chk("rst_state", state_o, ST_IDLE);
    resetn_a = 1'b1;

    // directed bring-up: full-rate AXI, error on beat 5 of the first burst
    base_addr_i = 64'h1000;
    top_addr_i = 64'h1200;
    err_beat = 5;
    en_next = 1'b1;
    step();
    req_pct = 100;
    step();
    req_pct = 0;
    step();
    chk("early_underflow", underflow_o, 1);
    chk("early_no_valid", pix_valid_o, 0);
    begin
      int n = 0;
      while (beat_total < 3 * BL && n < 400) begin step(); n++; end
    end
    run(20);
    chk("wait_bursts", ar_count, 3);
    chk("wait_no_arvalid", arvalid_o, 0);
    chk("wait_state", state_o, ST_WAIT);
    chk("rerr_beat5", rerr_o, 1);
    if (ar_log.size() >= 3) begin
      chk("ar0", ar_log[0], 64'h1000);
      chk("ar1", ar_log[1], 64'h1100);
      chk("ar2", ar_log[2], 64'h1000);
    end else begin
      chk("ar_log_size", ar_log.size(), 3);
    end

    pix_seen.delete();
    req_pct = 100;
    run(4);
    req_pct = 0;
    step();
    chk("first_pix_count", pix_seen.size(), 4);
    if (pix_seen.size() == 4) begin
      chk("pix0", pix_seen[0], 12'h789);
      chk("pix1", pix_seen[1], 12'h456);
      chk("pix2", pix_seen[2], 12'h123);
      chk("pix3", pix_seen[3], 12'hABC);
    end
    req_pct = 100;
    run(124);
    req_pct = 0;
    begin
      int n = 0;
      while (ar_count < 4 && n < 50) begin step(); n++; end
    end
    chk("fourth_burst", ar_count, 4);
    if (ar_log.size() >= 4) chk("ar3", ar_log[3], 64'h1100);

    // randomised episodes: drain with enable low, reprogram frame, then stream
    err_beat = -1;
    for (int ep = 0; ep < 3; ep++) begin
      en_next = 1'b0;
      req_pct = 0;
      resp_pct = 0;
      ar_pct = 50;
      r_pct = 60;
      run(10);
      begin
        int n = 0;
        while (beats_left > 0 && n < 400) begin step(); n++; end
        chk("drain_done", beats_left, 0);
      end
      run(3);
      chk("idle_state", state_o, ST_IDLE);
      chk("idle_arvalid", arvalid_o, 0);
      base_addr_i = AW'(64'h8000 + ep * 64'h10000);
      top_addr_i = base_addr_i + BYTES * AW'($urandom_range(1, 4)) + AW'($urandom_range(0, 200));
      en_next = 1'b1;
      step();
      ar_pct = $urandom_range(30, 100);
      r_pct = $urandom_range(30, 100);
      req_pct = $urandom_range(10, 70);
      resp_pct = 3;
      run(1500);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
